// File: rtl/diff_rebuild.sv
// diff_rebuild: rebuilds operand B from base A and a stream of increasing
// bit-position indices (the inverse of the ALU lowest-differing-bit op).
// B = A ^ mask, where each legal index sets one mask bit.
module diff_rebuild (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        start_empty,
  input  logic [31:0] base,
  input  logic        idx_valid,
  input  logic [5:0]  idx,
  input  logic        idx_last,
  output logic        idx_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] b_out,
  output logic [31:0] mask,
  output logic [5:0]  count,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, OUT} state_t;

  state_t      state;
  logic [31:0] aReg;
  logic [31:0] maskReg;
  logic [5:0]  countReg;
  logic        errReg;
  logic [4:0]  lastIdx;
  logic        havePrev;
  logic        beat;
  logic        legal;

  // An index is legal when in range and strictly above the previous accepted one
  always_comb begin
    beat  = idx_valid & idx_ready;
    legal = ~idx[5] & (~havePrev | (idx[4:0] > lastIdx));
  end

  // Control FSM with registered handshake outputs and the operand datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx_ready <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      aReg      <= 32'd0;
      maskReg   <= 32'd0;
      countReg  <= 6'd0;
      errReg    <= 1'b0;
      lastIdx   <= 5'd0;
      havePrev  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            aReg     <= base;
            maskReg  <= 32'd0;
            countReg <= 6'd0;
            errReg   <= 1'b0;
            lastIdx  <= 5'd0;
            havePrev <= 1'b0;
            busy     <= 1'b1;
            if (start_empty) begin
              state     <= OUT;
              out_valid <= 1'b1;
              idx_ready <= 1'b0;
            end else begin
              state     <= COLLECT;
              idx_ready <= 1'b1;
              out_valid <= 1'b0;
            end
          end
        end
        COLLECT: begin
          if (beat) begin
            if (legal) begin
              maskReg  <= maskReg | (32'd1 << idx[4:0]);
              countReg <= countReg + 6'd1;
              lastIdx  <= idx[4:0];
              havePrev <= 1'b1;
            end else begin
              errReg <= 1'b1;
            end
            if (idx_last) begin
              state     <= OUT;
              idx_ready <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          idx_ready <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Result is a pure function of registered state
  always_comb begin
    b_out = aReg ^ maskReg;
    mask  = maskReg;
    count = countReg;
    err   = errReg;
  end

endmodule

// File: tb/tb_diff_rebuild.sv
// tb_diff_rebuild: table-driven directed vectors plus hand-written sequences
// for reset abort, back-pressure with ignored start, and a full 32-index stream.
module tb_diff_rebuild;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        start_empty;
  logic [31:0] base;
  logic        idx_valid;
  logic [5:0]  idx;
  logic        idx_last;
  logic        idx_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] b_out;
  logic [31:0] mask;
  logic [5:0]  count;
  logic        err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0]     base;
    logic            empty;
    int              n;
    logic [4:0][5:0] idxs;
    logic [31:0]     expB;
    logic [31:0]     expMask;
    logic [5:0]      expCount;
    logic            expErr;
  } vec_t;

  vec_t vecs [6];

  diff_rebuild dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_empty(start_empty),
    .base(base), .idx_valid(idx_valid), .idx(idx), .idx_last(idx_last),
    .idx_ready(idx_ready), .out_valid(out_valid), .out_ready(out_ready),
    .b_out(b_out), .mask(mask), .count(count), .err(err), .busy(busy)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic setVec(input int k, input logic [31:0] b, input logic e, input int n,
                        input logic [5:0] i0, input logic [5:0] i1, input logic [5:0] i2,
                        input logic [5:0] i3, input logic [5:0] i4,
                        input logic [31:0] eb, input logic [31:0] em,
                        input logic [5:0] ec, input logic ee);
    vecs[k].base     = b;
    vecs[k].empty    = e;
    vecs[k].n        = n;
    vecs[k].idxs[0]  = i0;
    vecs[k].idxs[1]  = i1;
    vecs[k].idxs[2]  = i2;
    vecs[k].idxs[3]  = i3;
    vecs[k].idxs[4]  = i4;
    vecs[k].expB     = eb;
    vecs[k].expMask  = em;
    vecs[k].expCount = ec;
    vecs[k].expErr   = ee;
  endtask

  // Drive one full operation at full rate, then drain the result
  task automatic applyStimulus(input int k);
    @(negedge clk);
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    start       = 1'b1;
    start_empty = vecs[k].empty;
    base        = vecs[k].base;
    @(negedge clk);
    start = 1'b0;
    base  = 32'h0;
    checkOutput("start_busy", {31'd0, busy}, 32'd1);
    checkOutput("start_ready", {31'd0, idx_ready}, {31'd0, ~vecs[k].empty});
    checkOutput("start_valid", {31'd0, out_valid}, {31'd0, vecs[k].empty});
    for (int i = 0; i < vecs[k].n; i++) begin
      idx_valid = 1'b1;
      idx       = vecs[k].idxs[i];
      idx_last  = (i == vecs[k].n - 1);
      checkOutput("beat_ready", {31'd0, idx_ready}, 32'd1);
      checkOutput("beat_no_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
    idx_valid = 1'b0;
    idx_last  = 1'b0;
    checkOutput("res_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("res_ready_low", {31'd0, idx_ready}, 32'd0);
    checkOutput("res_b", b_out, vecs[k].expB);
    checkOutput("res_mask", mask, vecs[k].expMask);
    checkOutput("res_count", {26'd0, count}, {26'd0, vecs[k].expCount});
    checkOutput("res_err", {31'd0, err}, {31'd0, vecs[k].expErr});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("drain_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("drain_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_empty = 1'b0; base = 32'h0;
    idx_valid = 1'b0; idx = 6'd0; idx_last = 1'b0; out_ready = 1'b0;

    setVec(0, 32'h0000_00F0, 1'b0, 1, 6'd4, 6'd0, 6'd0, 6'd0, 6'd0,
           32'h0000_00E0, 32'h0000_0010, 6'd1, 1'b0);
    setVec(1, 32'hFFFF_FFFF, 1'b0, 3, 6'd0, 6'd5, 6'd31, 6'd0, 6'd0,
           32'h7FFF_FFDE, 32'h8000_0021, 6'd3, 1'b0);
    setVec(2, 32'h1234_5678, 1'b1, 0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0,
           32'h1234_5678, 32'h0, 6'd0, 1'b0);
    setVec(3, 32'h0000_0000, 1'b0, 5, 6'd3, 6'd3, 6'd2, 6'd40, 6'd7,
           32'h0000_0088, 32'h0000_0088, 6'd2, 1'b1);
    setVec(4, 32'hA5A5_A5A5, 1'b0, 2, 6'd1, 6'd2, 6'd0, 6'd0, 6'd0,
           32'hA5A5_A5A3, 32'h0000_0006, 6'd2, 1'b0);
    setVec(5, 32'h0F0F_0F0F, 1'b0, 1, 6'd40, 6'd0, 6'd0, 6'd0, 6'd0,
           32'h0F0F_0F0F, 32'h0, 6'd0, 1'b1);

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", {31'd0, idx_ready}, 32'd0);
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_b", b_out, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    // idx_valid in IDLE is not consumed
    @(negedge clk);
    idx_valid = 1'b1; idx = 6'd3; idx_last = 1'b1;
    @(negedge clk);
    checkOutput("idle_ignore_ready", {31'd0, idx_ready}, 32'd0);
    checkOutput("idle_ignore_busy", {31'd0, busy}, 32'd0);
    idx_valid = 1'b0; idx_last = 1'b0;

    for (int k = 0; k < 6; k++) applyStimulus(k);

    // Reset mid-COLLECT after three indices
    @(negedge clk);
    start = 1'b1; start_empty = 1'b0; base = 32'h5555_0000;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      idx_valid = 1'b1; idx = 6'(i); idx_last = 1'b0;
      @(negedge clk);
    end
    idx_valid = 1'b0;
    checkOutput("pre_rst_mask", mask, 32'h0000_000E);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_ready", {31'd0, idx_ready}, 32'd0);
    checkOutput("abort_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("abort_b", b_out, 32'd0);
    checkOutput("abort_mask", mask, 32'd0);
    checkOutput("abort_count", {26'd0, count}, 32'd0);
    checkOutput("abort_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1);

    // Back-pressure with ignored start pulses
    @(negedge clk);
    start = 1'b1; start_empty = 1'b0; base = 32'h0000_00F0;
    @(negedge clk);
    start = 1'b0;
    idx_valid = 1'b1; idx = 6'd4; idx_last = 1'b1;
    @(negedge clk);
    idx_valid = 1'b0; idx_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      start = 1'b1; start_empty = c[0]; base = 32'hDEAD_BEEF;
      @(negedge clk);
      checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_b", b_out, 32'h0000_00E0);
      checkOutput("bp_mask", mask, 32'h0000_0010);
      checkOutput("bp_count", {26'd0, count}, 32'd1);
      checkOutput("bp_err", {31'd0, err}, 32'd0);
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("bp_drain_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("bp_drain_busy", {31'd0, busy}, 32'd0);
    start = 1'b1; start_empty = 1'b1; base = 32'hCAFE_F00D;
    @(negedge clk);
    start = 1'b0;
    checkOutput("restart_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("restart_b", b_out, 32'hCAFE_F00D);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // All 32 indices: count reaches 32
    start = 1'b1; start_empty = 1'b0; base = 32'h0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      idx_valid = 1'b1; idx = 6'(i); idx_last = (i == 31);
      @(negedge clk);
    end
    idx_valid = 1'b0; idx_last = 1'b0;
    checkOutput("full_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("full_mask", mask, 32'hFFFF_FFFF);
    checkOutput("full_b", b_out, 32'hFFFF_FFFF);
    checkOutput("full_count", {26'd0, count}, 32'd32);
    checkOutput("full_err", {31'd0, err}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("full_drain_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
